// File: rtl/zbritesi_serik.sv
// Bit-serial subtractor: A - B - BIN, one bit per clock, LSB first.
// It uses a single full-subtractor cell and a Start/Busy/Done handshake.
// Result and flags are registered and held until the next completion or reset.
module zbritesi_serik #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic [WIDTH-1:0] Rezultati,
    output logic             BOUT,
    output logic             Zero,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last;
    logic             d;
    logic [WIDTH-1:0] d_full;

    // Borrow out of one full-subtractor cell.
    function automatic logic sub_borrow(input logic a0, input logic b0, input logic c);
        return (~a0 & b0) | (~a0 & c) | (b0 & c);
    endfunction

    assign accept = Start && ((state == IDLE) || (state == DONE));
    assign last   = (state == SHIFT) && (cnt == LAST_BIT);
    assign d      = a_sh[0] ^ b_sh[0] ^ borrow;
    // Difference bits gathered so far with the current bit placed on top.
    // On the completion edge this is exactly the finished result.
    assign d_full = {d, d_sh};

    assign Busy = (state == SHIFT);
    assign Done = (state == DONE);

    // State register; reset wins over any request.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept from IDLE/DONE, leave SHIFT after the MSB.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = Start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Serial datapath: operand capture on accept, one bit per edge in SHIFT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= BIN;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            d_sh   <= d_full[WIDTH-1:1];
            borrow <= sub_borrow(a_sh[0], b_sh[0], borrow);
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers: written only on the completion edge or cleared by reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Rezultati <= '0;
            BOUT      <= 1'b0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
        end else if (last) begin
            Rezultati <= d_full;
            BOUT      <= sub_borrow(a_sh[0], b_sh[0], borrow);
            Zero      <= (d_full == '0);
            Overflow  <= (a_msb != b_msb) && (d != a_msb);
        end
    end

endmodule

// File: tb/tb_zbritesi_serik.sv
// Self-checking bench for zbritesi_serik: a cycle model built from the
// operation's arithmetic, checked every cycle, plus directed literal cases.
module tb_zbritesi_serik;

    localparam int W = 24;

    logic         Clock;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BIN;
    logic [W-1:0] Rezultati;
    logic         BOUT;
    logic         Zero;
    logic         Overflow;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    zbritesi_serik #(.WIDTH(W)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .A(A),
        .B(B),
        .BIN(BIN),
        .Rezultati(Rezultati),
        .BOUT(BOUT),
        .Zero(Zero),
        .Overflow(Overflow),
        .Busy(Busy),
        .Done(Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: {overflow, borrow, result} of A - B - BIN from plain arithmetic.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic bin);
        logic [W:0] diff;
        longint     sd;
        logic       ovf;
        diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ovf  = (sd > longint'((1 << (W - 1)) - 1)) || (sd < -longint'(1 << (W - 1)));
        return {ovf, diff[W], diff[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Behavioural model: countdown of remaining busy cycles and held outputs.
    int           m_rem = 0;
    bit           m_done = 0;
    logic [W-1:0] m_res = '0;
    logic         m_bout = 0, m_zero = 0, m_ovf = 0;
    logic [W+1:0] m_pend = '0;

    always @(posedge Clock) begin
        cyc++;
        if (Reset) begin
            m_rem = 0; m_done = 0;
            m_res = '0; m_bout = 0; m_zero = 0; m_ovf = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = 0;
            if (m_rem == 0) begin
                m_res  = m_pend[W-1:0];
                m_bout = m_pend[W];
                m_ovf  = m_pend[W+1];
                m_zero = (m_pend[W-1:0] == '0);
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (Start) begin
                m_pend = ref_sub(A, B, BIN);
                m_rem  = W;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("cyc_res", 32'(Rezultati), 32'(m_res));
            chk("cyc_bout", 32'(BOUT), 32'(m_bout));
            chk("cyc_zero", 32'(Zero), 32'(m_zero));
            chk("cyc_ovf", 32'(Overflow), 32'(m_ovf));
            chk("cyc_busy", 32'(Busy), 32'(m_rem > 0));
            chk("cyc_done", 32'(Done), 32'(m_done));
            chk("busy_and_done", 32'(Busy && Done), 32'(0));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        A = a; B = b; BIN = bin; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Waits (bounded) for Done; returns at the negedge of the Done cycle.
    task automatic wait_done(output int busy_cnt);
        bit ok;
        ok = 0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (Done) begin
                ok = 1;
                break;
            end
            if (Busy) busy_cnt++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_60_cycles");
        end
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] res, input logic bout,
                           input logic zero, input logic ovf);
        chk({name, "_res"}, 32'(Rezultati), 32'(res));
        chk({name, "_bout"}, 32'(BOUT), 32'(bout));
        chk({name, "_zero"}, 32'(Zero), 32'(zero));
        chk({name, "_ovf"}, 32'(Overflow), 32'(ovf));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int           bc;
        int           t1, t2, dcnt;
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W+1:0] r;

        Reset = 1'b1; Start = 1'b0; A = '0; B = '0; BIN = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        chk_en = 1;
        chk_out("reset", 24'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", 32'(Busy), 32'(0));
        chk("reset_done", 32'(Done), 32'(0));

        // 5 - 3
        start_op(24'd5, 24'd3, 1'b0);
        wait_done(bc);
        chk("t1_busy_cycles", 32'(bc), 32'(24));
        chk_out("t1", 24'h000002, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        chk("t1_done_one_cycle", 32'(Done), 32'(0));
        chk("t1_held_res", 32'(Rezultati), 32'h000002);

        // Borrow and signed overflow
        start_op(24'd3, 24'd5, 1'b0);
        wait_done(bc);
        chk_out("t2a", 24'hFFFFFE, 1'b1, 1'b0, 1'b0);
        start_op(24'h800000, 24'h000001, 1'b0);
        wait_done(bc);
        chk_out("t2b", 24'h7FFFFF, 1'b0, 1'b0, 1'b1);

        // Zero and borrow-in
        start_op(24'd7, 24'd7, 1'b0);
        wait_done(bc);
        chk_out("t3a", 24'h000000, 1'b0, 1'b1, 1'b0);
        start_op(24'd7, 24'd7, 1'b1);
        wait_done(bc);
        chk_out("t3b", 24'hFFFFFF, 1'b1, 1'b0, 1'b0);

        // Start mid-SHIFT is ignored
        @(negedge Clock);
        start_op(24'h000100, 24'h000001, 1'b0);
        repeat (5) tick();
        A = 24'hFFFFFF; B = 24'h0; BIN = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(bc);
        chk_out("t4_ignore", 24'h0000FF, 1'b0, 1'b0, 1'b0);

        // Start held high through DONE: back-to-back
        @(negedge Clock);
        start_op(24'h000010, 24'h000001, 1'b0);
        Start = 1'b1;
        wait_done(bc);
        t1 = cyc;
        chk_out("t5_first", 24'h00000F, 1'b0, 1'b0, 1'b0);
        A = 24'h000020; B = 24'h000002; BIN = 1'b0;
        tick();
        Start = 1'b0;
        wait_done(bc);
        t2 = cyc;
        chk("t5_done_spacing", 32'(t2 - t1), 32'(25));
        chk_out("t5_second", 24'h00001E, 1'b0, 1'b0, 1'b0);

        // Reset mid-SHIFT aborts
        @(negedge Clock);
        start_op(24'h123456, 24'h654321, 1'b0);
        repeat (9) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_out("t6_reset", 24'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_busy", 32'(Busy), 32'(0));
        chk("t6_done", 32'(Done), 32'(0));
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Done) dcnt++;
        end
        chk("t6_no_done", 32'(dcnt), 32'(0));
        start_op(24'd5, 24'd3, 1'b1);
        wait_done(bc);
        chk("t6_busy_cycles", 32'(bc), 32'(24));
        chk_out("t6_after", 24'h000001, 1'b0, 1'b0, 1'b0);

        // Random vectors, started back-to-back from DONE
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            if (n % 50 == 0) rb = ra;
            r = ref_sub(ra, rb, rbin);
            start_op(ra, rb, rbin);
            wait_done(bc);
            chk_out("rand", r[W-1:0], r[W], (r[W-1:0] == '0), r[W+1]);
        end

        @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zbritesi_serik.md
# zbritesi_serik

Bit-serial WIDTH-bit subtractor for the 24-bit CPU datapath. It computes A − B − BIN, one bit per clock, LSB first, using a single full-subtractor cell (difference = a ^ b ^ borrow). It uses a Start/Busy/Done handshake and registered result and flags. It is the low-area subtract counterpart to the ripple adder, for the ALU's multi-cycle path.

## Interface

- WIDTH, 24, operand and result width in bits (≥ 2)

- Clock  in  1  rising-edge clock; the only clock
- Reset  in  1  synchronous, active-high; sampled on the Clock rising edge
- Start  in  1  request; accepted only in IDLE or DONE
- A  in  WIDTH  minuend; sampled on the accepting edge only
- B  in  WIDTH  subtrahend; sampled on the accepting edge only
- BIN  in  1  borrow-in; sampled on the accepting edge only
- Rezultati  out  WIDTH  A − B − BIN mod 2^WIDTH; registered
- BOUT  out  1  borrow out of the MSB (1 ⇔ unsigned A < B + BIN)
- Zero  out  1  Rezultati == 0
- Overflow  out  1  signed two's-complement overflow
- Busy  out  1  high while in SHIFT
- Done  out  1  one-cycle pulse when a new result is valid

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE, Start=1: latch A and B into shift registers, set the borrow register to BIN, latch A[WIDTH-1] and B[WIDTH-1], clear the bit counter, go to SHIFT.
- SHIFT, every edge:
  - a0 = A_sh[0], b0 = B_sh[0], c = borrow.
  - d = a0 ^ b0 ^ c.
  - borrow ← (~a0 & b0) | (~a0 & c) | (b0 & c).
  - D_sh ← {d, D_sh[WIDTH-1:1]}.
  - A_sh and B_sh shift right by 1.
  - Counter increments.
- SHIFT, edge that processes bit WIDTH-1:
  - Load Rezultati from the final shifted value, with d as MSB.
  - BOUT ← final borrow.
  - Zero ← (final value == 0).
  - Overflow ← (Amsb ≠ Bmsb) & (d ≠ Amsb).
  - Go to DONE.
- DONE: Done=1 for exactly one cycle.
  - Start=1 is accepted exactly as in IDLE and goes to SHIFT, allowing back-to-back operations.
  - Otherwise go to IDLE.
- Start while in SHIFT is ignored; the operation in flight is not disturbed.
- Output registers change only on the completion edge or on Reset. They hold the last result through IDLE and through any following SHIFT.
- BIN feeds the subtraction, and the Overflow rule uses the latched operand MSBs.

## Timing

- Reset (wins over Start):
  - State goes to IDLE and the counter clears.
  - Rezultati, BOUT, Zero, Overflow, Busy and Done all go to 0.
  - Zero resets to 0, not 1; it is valid only after the first Done.
- Reset mid-SHIFT aborts the operation. No Done is produced and the outputs read 0.
- Start accepted at edge k:
  - Busy=1 during cycles k..k+WIDTH−1, i.e. exactly WIDTH cycles.
  - The result and flags update at edge k+WIDTH.
  - Done=1 and Busy=0 during cycle k+WIDTH.
- Latency from Start edge to Done is WIDTH edges. Throughput is one result per WIDTH+1 cycles when Start is held high.
- Counter width is clog2(WIDTH). The counter has no wrap-around hazard because it clears on each accept.
- Done and Busy are never high in the same cycle.

## Test plan

- A=5, B=3, BIN=0, WIDTH=24 → after 24 edges Rezultati=0x000002, BOUT=0, Zero=0, Overflow=0; Done high exactly one cycle; Busy high exactly 24 cycles.
- A=3, B=5 → Rezultati=0xFFFFFE, BOUT=1, Overflow=0. Then A=0x800000, B=0x000001 → Rezultati=0x7FFFFF, BOUT=0, Overflow=1.
- A=7, B=7, BIN=0 → Rezultati=0, Zero=1. Same with BIN=1 → Rezultati=0xFFFFFF, BOUT=1, Zero=0.
- Start pulsed again mid-SHIFT with different operands → ignored; the original result appears on schedule. Start held high through DONE → second operation begins and its Done arrives 25 cycles after the first.
- Reset asserted on cycle 10 of SHIFT → next cycle all outputs are 0 and the state is IDLE; no Done ever appears; a new Start completes normally.
- Random A, B, BIN (≥1000 vectors) against a reference model of {BOUT, Rezultati} = A − B − BIN, plus the signed Overflow rule → all match.
